// File: rtl/occ_request_issuer.sv
`default_nettype none
// ============================================================================
// Module      : occ_request_issuer
// Description : Request side of the occurrence-table memory path. Each
//               accepted pipeline entry produces two DRAM line reads: first
//               the k line (tag 0), then the l line (tag 1). A credit counter
//               limits the number of entries in flight to the depth of the
//               downstream response FIFO, so that FIFO cannot overflow.
// Ports       : Clk_32UI, reset_n         - clock, synchronous active-low reset
//               req_valid/req_ready       - pipeline entry handshake
//               req_status                - entry status (BUBBLE = discard)
//               req_ik_x0, req_ik_x2      - interval start k and size s
//               dram_req_valid/ready      - DRAM read request handshake
//               dram_req_addr/tag         - line byte address, 0=k / 1=l
//               mem_pop                   - one response consumed, frees a credit
//               outstanding               - credits in use (0..MAX_OUT)
//               err_underflow             - sticky: mem_pop seen with no credit used
// Revision    : 1.0 - initial release
// ============================================================================
module occ_request_issuer #(
    parameter int          MAX_OUT   = 32,
    parameter int          OCC_SHIFT = 7,
    parameter int          LINE_LOG2 = 6,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter logic [5:0]  BUBBLE    = 6'b110000
) (
    input  logic        Clk_32UI,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic [5:0]  req_status,
    input  logic [63:0] req_ik_x0,
    input  logic [63:0] req_ik_x2,
    output logic        req_ready,
    output logic        dram_req_valid,
    output logic [63:0] dram_req_addr,
    output logic        dram_req_tag,
    input  logic        dram_req_ready,
    input  logic        mem_pop,
    output logic [5:0]  outstanding,
    output logic        err_underflow
);

    localparam logic [5:0] MAX_OUT_W = 6'(MAX_OUT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE_K = 2'd1,
        ST_ISSUE_L = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_k_q, addr_k_d;
    logic [63:0] addr_l_q, addr_l_d;
    logic [5:0]  outstanding_q, outstanding_d;
    logic        err_q, err_d;

    logic [63:0] sum_ks;
    logic [63:0] pos_k;
    logic [63:0] pos_l;
    logic        can_take;
    logic        accept;
    logic        take;
    logic        pop_ok;

    // Line addresses of the occ entries at positions k-1 and k+s-1; a zero
    // position clamps to 0 instead of wrapping to all-ones.
    always_comb begin
        sum_ks   = req_ik_x0 + req_ik_x2;
        pos_k    = (req_ik_x0 == 64'd0) ? 64'd0 : req_ik_x0 - 64'd1;
        pos_l    = (sum_ks == 64'd0) ? 64'd0 : sum_ks - 64'd1;
        addr_k_d = BASE_ADDR + ((pos_k >> OCC_SHIFT) << LINE_LOG2);
        addr_l_d = BASE_ADDR + ((pos_l >> OCC_SHIFT) << LINE_LOG2);
    end

    // The credit gate uses the registered count, so a mem_pop at the cap
    // only opens req_ready on the following cycle.
    assign can_take = (outstanding_q < MAX_OUT_W);
    assign pop_ok   = mem_pop && (outstanding_q != 6'd0);

    always_comb begin
        state_d        = state_q;
        req_ready      = 1'b0;
        dram_req_valid = 1'b0;
        dram_req_tag   = 1'b0;
        dram_req_addr  = addr_k_q;

        case (state_q)
            ST_IDLE: begin
                req_ready = reset_n && can_take;
            end
            ST_ISSUE_K: begin
                dram_req_valid = 1'b1;
                if (dram_req_ready) begin
                    state_d = ST_ISSUE_L;
                end
            end
            ST_ISSUE_L: begin
                dram_req_valid = 1'b1;
                dram_req_tag   = 1'b1;
                dram_req_addr  = addr_l_q;
                // A new entry may only enter as the l request leaves, which
                // keeps addr_k/addr_l stable for the whole in-flight pair.
                req_ready      = reset_n && can_take && dram_req_ready;
                if (dram_req_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        accept = req_valid && req_ready;
        take   = accept && (req_status != BUBBLE);
        if (take) begin
            state_d = ST_ISSUE_K;
        end
    end

    always_comb begin
        outstanding_d = outstanding_q;
        err_d         = err_q;
        if (take && !pop_ok) begin
            outstanding_d = outstanding_q + 6'd1;
        end else if (!take && pop_ok) begin
            outstanding_d = outstanding_q - 6'd1;
        end
        if (mem_pop && (outstanding_q == 6'd0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_32UI) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_k_q      <= 64'd0;
            addr_l_q      <= 64'd0;
            outstanding_q <= 6'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            err_q         <= err_d;
            if (take) begin
                addr_k_q <= addr_k_d;
                addr_l_q <= addr_l_d;
            end
        end
    end

    assign outstanding   = outstanding_q;
    assign err_underflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_occ_request_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_occ_request_issuer
// Description : Directed self-checking bench for occ_request_issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_occ_request_issuer;

    localparam logic [5:0] BUBBLE = 6'b110000;

    logic        Clk_32UI;
    logic        reset_n;
    logic        req_valid;
    logic [5:0]  req_status;
    logic [63:0] req_ik_x0;
    logic [63:0] req_ik_x2;
    logic        req_ready;
    logic        dram_req_valid;
    logic [63:0] dram_req_addr;
    logic        dram_req_tag;
    logic        dram_req_ready;
    logic        mem_pop;
    logic [5:0]  outstanding;
    logic        err_underflow;

    int n_checks = 0;
    int n_bad    = 0;
    int n_acc    = 0;
    int n_dram   = 0;
    int n_dram_l = 0;

    // Hand-computed clamp/boundary vectors: k, s, expected k line, expected l line
    localparam logic [63:0] VK [4] = '{64'h0,  64'h0, 64'h80, 64'h81};
    localparam logic [63:0] VS [4] = '{64'h0,  64'h1, 64'h1,  64'h80};
    localparam logic [63:0] EK [4] = '{64'h0,  64'h0, 64'h0,  64'h40};
    localparam logic [63:0] EL [4] = '{64'h0,  64'h0, 64'h40, 64'h80};

    occ_request_issuer dut (
        .Clk_32UI       (Clk_32UI),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_status     (req_status),
        .req_ik_x0      (req_ik_x0),
        .req_ik_x2      (req_ik_x2),
        .req_ready      (req_ready),
        .dram_req_valid (dram_req_valid),
        .dram_req_addr  (dram_req_addr),
        .dram_req_tag   (dram_req_tag),
        .dram_req_ready (dram_req_ready),
        .mem_pop        (mem_pop),
        .outstanding    (outstanding),
        .err_underflow  (err_underflow)
    );

    initial Clk_32UI = 1'b0;
    always #5 Clk_32UI = ~Clk_32UI;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record handshakes of the current cycle, then advance to 1ns past the next edge.
    task automatic tick();
        #1;
        if (req_valid && req_ready) n_acc++;
        if (dram_req_valid && dram_req_ready) begin
            n_dram++;
            if (dram_req_tag) n_dram_l++;
        end
        @(posedge Clk_32UI);
        #1;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 70 && outstanding != 6'd0; i++) begin
            mem_pop = 1'b1;
            tick();
        end
        mem_pop = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b1; req_status = 6'd0;
        req_ik_x0 = 64'h100; req_ik_x2 = 64'h0; dram_req_ready = 1'b0; mem_pop = 1'b0;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got=%b want=0", req_ready); end
        @(posedge Clk_32UI); #1;
        @(posedge Clk_32UI); #1;
        n_checks++; if (dram_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", dram_req_valid); end
        n_checks++; if (dram_req_addr !== 64'h0) begin n_bad++; $display("FAIL reset_addr got=%h want=0", dram_req_addr); end
        n_checks++; if (dram_req_tag !== 1'b0) begin n_bad++; $display("FAIL reset_tag got=%b want=0", dram_req_tag); end
        n_checks++; if (outstanding !== 6'd0) begin n_bad++; $display("FAIL reset_outstanding got=%0d want=0", outstanding); end
        n_checks++; if (err_underflow !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_underflow); end
        req_valid = 1'b0;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_addr_basic();
        dram_req_ready = 1'b1;
        req_valid = 1'b1; req_status = 6'd0; req_ik_x0 = 64'h100; req_ik_x2 = 64'h80;
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got=%b want=1", req_ready); end
        tick();
        req_valid = 1'b0;
        n_checks++; if (dram_req_valid !== 1'b1 || dram_req_tag !== 1'b0) begin n_bad++; $display("FAIL basic_k_vt got=%b%b want=10", dram_req_valid, dram_req_tag); end
        n_checks++; if (dram_req_addr !== 64'h40) begin n_bad++; $display("FAIL basic_k_addr got=%h want=40", dram_req_addr); end
        n_checks++; if (outstanding !== 6'd1) begin n_bad++; $display("FAIL basic_outstanding got=%0d want=1", outstanding); end
        tick();
        n_checks++; if (dram_req_valid !== 1'b1 || dram_req_tag !== 1'b1) begin n_bad++; $display("FAIL basic_l_vt got=%b%b want=11", dram_req_valid, dram_req_tag); end
        // pos_l = 0x17F -> line 2 -> byte address 0x80
        n_checks++; if (dram_req_addr !== 64'h80) begin n_bad++; $display("FAIL basic_l_addr got=%h want=80", dram_req_addr); end
        tick();
        n_checks++; if (dram_req_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle_valid got=%b want=0", dram_req_valid); end
        mem_pop = 1'b1;
        tick();
        mem_pop = 1'b0;
        n_checks++; if (outstanding !== 6'd0) begin n_bad++; $display("FAIL basic_pop got=%0d want=0", outstanding); end
    endtask

    task automatic test_clamp();
        dram_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_status = 6'd0; req_ik_x0 = VK[i]; req_ik_x2 = VS[i];
            tick();
            req_valid = 1'b0;
            n_checks++; if (dram_req_addr !== EK[i] || dram_req_tag !== 1'b0) begin n_bad++; $display("FAIL clamp_k[%0d] got=%h/%b want=%h/0", i, dram_req_addr, dram_req_tag, EK[i]); end
            tick();
            n_checks++; if (dram_req_addr !== EL[i] || dram_req_tag !== 1'b1) begin n_bad++; $display("FAIL clamp_l[%0d] got=%h/%b want=%h/1", i, dram_req_addr, dram_req_tag, EL[i]); end
            tick();
        end
        n_checks++; if (outstanding !== 6'd4) begin n_bad++; $display("FAIL clamp_outstanding got=%0d want=4", outstanding); end
        drain();
    endtask

    task automatic test_stall();
        n_acc = 0;
        dram_req_ready = 1'b0;
        req_valid = 1'b1; req_status = 6'd0; req_ik_x0 = 64'h1000; req_ik_x2 = 64'h10;
        tick();
        // Keep offering a different entry; it must not be taken nor disturb the latched pair.
        req_ik_x0 = 64'h5000;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (dram_req_valid !== 1'b1 || dram_req_tag !== 1'b0 || dram_req_addr !== 64'h7C0 || req_ready !== 1'b0 || outstanding !== 6'd1) begin
                n_bad++;
                $display("FAIL stall[%0d] got v=%b t=%b a=%h rdy=%b out=%0d want v=1 t=0 a=7c0 rdy=0 out=1", i, dram_req_valid, dram_req_tag, dram_req_addr, req_ready, outstanding);
            end
            tick();
        end
        req_valid = 1'b0;
        dram_req_ready = 1'b1;
        tick();
        n_checks++; if (dram_req_addr !== 64'h800 || dram_req_tag !== 1'b1) begin n_bad++; $display("FAIL stall_l got=%h/%b want=800/1", dram_req_addr, dram_req_tag); end
        tick();
        n_checks++; if (n_acc !== 1) begin n_bad++; $display("FAIL stall_accepts got=%0d want=1", n_acc); end
        drain();
    endtask

    task automatic test_credits();
        n_acc = 0; n_dram = 0;
        dram_req_ready = 1'b1;
        req_valid = 1'b1; req_status = 6'd0; req_ik_x2 = 64'h1;
        for (int c = 0; c < 200 && n_acc < 40; c++) begin
            req_ik_x0 = 64'(c) * 64'd128;
            tick();
        end
        #1;
        n_checks++; if (n_acc !== 32) begin n_bad++; $display("FAIL credit_cap got=%0d want=32", n_acc); end
        n_checks++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_ready_full got=%b want=0", req_ready); end
        n_checks++; if (outstanding !== 6'd32) begin n_bad++; $display("FAIL credit_outstanding got=%0d want=32", outstanding); end
        mem_pop = 1'b1;
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL credit_ready_popcycle got=%b want=0", req_ready); end
        tick();
        mem_pop = 1'b0;
        #1;
        n_checks++; if (outstanding !== 6'd31 || req_ready !== 1'b1) begin n_bad++; $display("FAIL credit_after_pop got out=%0d rdy=%b want out=31 rdy=1", outstanding, req_ready); end
        for (int c = 0; c < 10; c++) tick();
        n_checks++; if (n_acc !== 33) begin n_bad++; $display("FAIL credit_one_more got=%0d want=33", n_acc); end
        n_checks++; if (n_dram !== 66) begin n_bad++; $display("FAIL credit_dram_reqs got=%0d want=66", n_dram); end
        drain();
    endtask

    task automatic test_bubble();
        n_acc = 0; n_dram = 0; n_dram_l = 0;
        dram_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bit got;
            got = 1'b0;
            req_valid = 1'b1;
            req_status = (i % 2 == 0) ? BUBBLE : 6'd1;
            req_ik_x0 = 64'(i) * 64'h1000; req_ik_x2 = 64'h10;
            for (int c = 0; c < 10 && !got; c++) begin
                #1;
                if (req_ready) got = 1'b1;
                tick();
            end
            n_checks++; if (!got) begin n_bad++; $display("FAIL bubble_accept_timeout[%0d] got=0 want=1", i); end
        end
        req_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        n_checks++; if (n_dram !== 8 || n_dram_l !== 4) begin n_bad++; $display("FAIL bubble_dram got=%0d/%0d want=8/4", n_dram, n_dram_l); end
        n_checks++; if (outstanding !== 6'd4) begin n_bad++; $display("FAIL bubble_outstanding got=%0d want=4", outstanding); end
        n_checks++; if (n_acc !== 8) begin n_bad++; $display("FAIL bubble_accepts got=%0d want=8", n_acc); end
        drain();
    endtask

    task automatic test_underflow();
        drain();
        mem_pop = 1'b1;
        tick();
        mem_pop = 1'b0;
        n_checks++; if (err_underflow !== 1'b1 || outstanding !== 6'd0) begin n_bad++; $display("FAIL underflow got err=%b out=%0d want err=1 out=0", err_underflow, outstanding); end
        tick();
        n_checks++; if (err_underflow !== 1'b1) begin n_bad++; $display("FAIL underflow_sticky got=%b want=1", err_underflow); end
    endtask

    task automatic test_reset_mid();
        dram_req_ready = 1'b1;
        req_valid = 1'b1; req_status = 6'd0; req_ik_x0 = 64'h100; req_ik_x2 = 64'h80;
        tick();
        req_valid = 1'b0;
        tick();
        dram_req_ready = 1'b0;
        #1;
        n_checks++; if (dram_req_valid !== 1'b1 || dram_req_tag !== 1'b1 || outstanding !== 6'd1) begin n_bad++; $display("FAIL mid_in_l got v=%b t=%b out=%0d want 1 1 1", dram_req_valid, dram_req_tag, outstanding); end
        reset_n = 1'b0;
        tick();
        n_checks++; if (dram_req_valid !== 1'b0 || outstanding !== 6'd0) begin n_bad++; $display("FAIL mid_reset got v=%b out=%0d want v=0 out=0", dram_req_valid, outstanding); end
        n_checks++; if (err_underflow !== 1'b0 || dram_req_addr !== 64'h0 || dram_req_tag !== 1'b0) begin n_bad++; $display("FAIL mid_reset_regs got err=%b a=%h t=%b want 0 0 0", err_underflow, dram_req_addr, dram_req_tag); end
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_addr_basic();
        test_clamp();
        test_stall();
        test_credits();
        test_bubble();
        test_underflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
